// File: rtl/var_delay_line.sv
// Multi-channel delay line with a run-time selectable tap (0..MAX_DELAY stages),
// per-word valid tracking, flush, and a count of valid words ahead of the tap.
module var_delay_line #(
  parameter int WIDTH         = 17,
  parameter int CHANNELS      = 2,
  parameter int MAX_DELAY     = 8,
  parameter int DEFAULT_DELAY = 2,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      cfg_we_i,
  input  logic [DW-1:0]             delay_sel_i,
  input  logic                      valid_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic                      valid_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [DW-1:0]             delay_o,
  output logic [DW-1:0]             occupancy_o,
  output logic                      idle_o,
  output logic                      cfg_err_o
);

  localparam int CW = CHANNELS * WIDTH;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);

  // Index s-1 holds physical stage s.
  logic [MAX_DELAY-1:0] valid_q, valid_d;
  logic [CW-1:0]        data_q [MAX_DELAY];
  logic [CW-1:0]        data_d [MAX_DELAY];
  logic [DW-1:0]        delay_q, delay_d;
  logic [DW-1:0]        occ_q, occ_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 tap_valid;
  logic [CW-1:0]        tap_data;
  logic                 idle;
  logic                 sel_over;
  logic                 cfg_ok;

  assign idle     = (occ_q == '0);
  assign sel_over = (delay_sel_i > MAX_D);
  assign cfg_ok   = cfg_we_i && (idle || flush_i);

  // Delay 0 is a pure combinational bypass of the input word.
  always_comb begin
    tap_valid = valid_i;
    tap_data  = data_i;
    if (delay_q != '0) begin
      tap_valid = 1'b0;
      tap_data  = '0;
      for (int s = 1; s <= MAX_DELAY; s++) begin
        if (delay_q == DW'(s)) begin
          tap_valid = valid_q[s-1];
          tap_data  = data_q[s-1];
        end
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    delay_d   = delay_q;
    occ_d     = occ_q;
    cfg_err_d = 1'b0;

    if (en_i) begin
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int s = 1; s < MAX_DELAY; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
      end
      if (delay_q != '0)
        occ_d = occ_q + DW'(valid_i) - DW'(tap_valid);
    end

    // Flush and accepted reconfiguration drop every in-flight word; data is kept.
    if (flush_i || cfg_ok) begin
      valid_d = '0;
      occ_d   = '0;
    end

    if (cfg_ok)
      delay_d = sel_over ? MAX_D : delay_sel_i;

    if (cfg_we_i && (!cfg_ok || sel_over))
      cfg_err_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q   <= '0;
      for (int s = 0; s < MAX_DELAY; s++) data_q[s] <= '0;
      delay_q   <= DW'(DEFAULT_DELAY);
      occ_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      delay_q   <= delay_d;
      occ_q     <= occ_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign valid_o     = tap_valid;
  assign data_o      = tap_data;
  assign delay_o     = delay_q;
  assign occupancy_o = occ_q;
  assign idle_o      = idle;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: a per-cycle vector table plus hand-written
// sequences for latency measurement and reset while words are in flight.
module tb_var_delay_line;

  localparam int CW = 34;
  localparam int DW = 4;

  logic          clock_i = 1'b0;
  logic          reset_i, en_i, flush_i, cfg_we_i, valid_i;
  logic [DW-1:0] delay_sel_i;
  logic [CW-1:0] data_i;
  logic          valid_o, idle_o, cfg_err_o;
  logic [CW-1:0] data_o;
  logic [DW-1:0] delay_o, occupancy_o;

  var_delay_line dut (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .cfg_we_i(cfg_we_i), .delay_sel_i(delay_sel_i), .valid_i(valid_i),
    .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .delay_o(delay_o),
    .occupancy_o(occupancy_o), .idle_o(idle_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic          en, fl, cfg;
    logic [DW-1:0] sel;
    logic          v;
    logic [CW-1:0] d;
    logic          ev, cd;
    logic [CW-1:0] ed;
    logic [DW-1:0] edly, eocc;
    logic          eerr;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [CW-1:0] mk(input logic [16:0] w);
    return {w ^ 17'h1ffff, w};
  endfunction

  function automatic vec_t V(input logic en, fl, cfg, input logic [DW-1:0] sel,
                             input logic v, input logic [CW-1:0] d,
                             input logic ev, cd, input logic [CW-1:0] ed,
                             input logic [DW-1:0] dly, occ, input logic err);
    vec_t r;
    r.en = en; r.fl = fl; r.cfg = cfg; r.sel = sel; r.v = v; r.d = d;
    r.ev = ev; r.cd = cd; r.ed = ed; r.edly = dly; r.eocc = occ; r.eerr = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid_o"},     64'(valid_o),     64'(0));
    chk({tag, " data_o"},      64'(data_o),      64'(0));
    chk({tag, " delay_o"},     64'(delay_o),     64'(2));
    chk({tag, " occupancy_o"}, 64'(occupancy_o), 64'(0));
    chk({tag, " idle_o"},      64'(idle_o),      64'(1));
    chk({tag, " cfg_err_o"},   64'(cfg_err_o),   64'(0));
  endtask

  initial begin
    int edges;
    int stale;

    // Default delay 2: three back-to-back words
    tbl.push_back(V(1,0,0,0,1,mk(1),   0,1,0,       2,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(2),   0,1,0,       2,1,0));
    tbl.push_back(V(1,0,0,0,1,mk(3),   1,1,mk(1),   2,2,0));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(2),   2,2,0));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(3),   2,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       0,1,0,       2,0,0));
    // Delay 3 with a 4-cycle enable gap
    tbl.push_back(V(0,0,1,3,0,0,       0,1,0,       2,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h1abcd), 0,1,0, 3,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(V(0,0,0,0,0,0, 0,1,0, 3,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       0,1,0,       3,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       0,1,0,       3,1,0));
    tbl.push_back(V(0,0,0,0,0,0,       1,1,mk(17'h1abcd), 3,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(17'h1abcd), 3,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       0,1,0,       3,0,0));
    // Delay 0 bypass, then delay 8, then clamped request 9
    tbl.push_back(V(1,0,1,0,1,mk(5),   0,1,0,       3,0,0));
    tbl.push_back(V(0,0,0,0,1,mk(7),   1,1,mk(7),   0,0,0));
    tbl.push_back(V(1,0,0,0,0,mk(9),   0,1,mk(9),   0,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(2),   1,1,mk(2),   0,0,0));
    tbl.push_back(V(0,0,1,8,0,0,       0,1,0,       0,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h155), 0,0,0,   8,0,0));
    for (int k = 0; k < 7; k++) tbl.push_back(V(1,0,0,0,0,0, 0,0,0, 8,1,0));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(17'h155), 8,1,0));
    tbl.push_back(V(0,0,1,9,0,0,       0,0,0,       8,0,0));
    tbl.push_back(V(0,0,0,0,0,0,       0,0,0,       8,0,1));
    // Delay 4: request while two words are in flight is rejected
    tbl.push_back(V(0,0,1,4,0,0,       0,0,0,       8,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h11), 0,0,0,    4,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h22), 0,0,0,    4,1,0));
    tbl.push_back(V(1,0,1,1,0,0,       0,0,0,       4,2,0));
    tbl.push_back(V(1,0,0,0,0,0,       0,0,0,       4,2,1));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(17'h11), 4,2,0));
    tbl.push_back(V(1,0,0,0,0,0,       1,1,mk(17'h22), 4,1,0));
    // Delay 5: flush with three in flight plus same-cycle valid_i and cfg to 1
    tbl.push_back(V(1,0,1,5,0,0,       0,0,0,       4,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h31), 0,0,0,    5,0,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h32), 0,0,0,    5,1,0));
    tbl.push_back(V(1,0,0,0,1,mk(17'h33), 0,0,0,    5,2,0));
    tbl.push_back(V(1,1,1,1,1,mk(17'h34), 0,0,0,    5,3,0));
    for (int k = 0; k < 6; k++) tbl.push_back(V(1,0,0,0,0,0, 0,0,0, 1,0,0));

    reset_i = 1'b1; en_i = 1'b0; flush_i = 1'b0; cfg_we_i = 1'b0;
    delay_sel_i = '0; valid_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(negedge clock_i);
    chk_reset_state("reset");
    @(posedge clock_i); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      en_i = tbl[i].en; flush_i = tbl[i].fl; cfg_we_i = tbl[i].cfg;
      delay_sel_i = tbl[i].sel; valid_i = tbl[i].v; data_i = tbl[i].d;
      @(negedge clock_i);
      chk($sformatf("row%0d valid_o", i),     64'(valid_o),     64'(tbl[i].ev));
      if (tbl[i].cd)
        chk($sformatf("row%0d data_o", i),    64'(data_o),      64'(tbl[i].ed));
      chk($sformatf("row%0d delay_o", i),     64'(delay_o),     64'(tbl[i].edly));
      chk($sformatf("row%0d occupancy_o", i), 64'(occupancy_o), 64'(tbl[i].eocc));
      chk($sformatf("row%0d idle_o", i),      64'(idle_o),      64'(tbl[i].eocc == 0));
      chk($sformatf("row%0d cfg_err_o", i),   64'(cfg_err_o),   64'(tbl[i].eerr));
      @(posedge clock_i); #1;
    end

    en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
    cfg_we_i = 1'b1; delay_sel_i = 4'd6;
    @(posedge clock_i); #1 cfg_we_i = 1'b0;
    chk("cfg6 delay_o", 64'(delay_o), 64'(6));

    // Latency at delay 6, counted in enabled edges
    en_i = 1'b1; valid_i = 1'b1; data_i = mk(17'h1234);
    @(posedge clock_i); #1 valid_i = 1'b0; data_i = '0;
    edges = 1;
    while (!valid_o && edges < 20) begin
      @(posedge clock_i); #1;
      edges++;
    end
    chk("lat6 edges", 64'(edges), 64'(6));
    chk("lat6 data_o", 64'(data_o), 64'(mk(17'h1234)));
    @(posedge clock_i); #1;
    chk("lat6 drained occupancy", 64'(occupancy_o), 64'(0));

    // Reset with four words in flight and enable low
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1; data_i = mk(17'(32'h40 + k));
      @(posedge clock_i); #1;
    end
    valid_i = 1'b0; data_i = '0; en_i = 1'b0;
    chk("inflight occupancy", 64'(occupancy_o), 64'(4));
    reset_i = 1'b1;
    @(posedge clock_i); #1 reset_i = 1'b0;
    chk_reset_state("midreset");
    en_i = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clock_i); #1;
      if (valid_o) stale++;
    end
    chk("midreset stale valid_o", 64'(stale), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/var_delay_line.md
# var_delay_line

Runtime-configurable, multi-channel delay line with per-word valid tracking, flush and an in-flight occupancy counter. It is the generalised successor of the fixed single-channel delay line: the same enable-gated shift behaviour, plus a delay selected at run time up to MAX_DELAY stages. It aligns operand and carry words between DSP pipeline stages of the FIOS Montgomery datapath, where the required skew depends on the configured operand size.

## Interface
- WIDTH, 17: bits per channel word.
- CHANNELS, 2: parallel words that share one valid bit and one delay.
- MAX_DELAY, 8: number of physical stages (≥1).
- DEFAULT_DELAY, 2: active delay after reset (0..MAX_DELAY).
- DW = $clog2(MAX_DELAY+1) (local): width of delay select and occupancy count.
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- en_i  in  1  shift enable; low = all state holds.
- flush_i  in  1  clear all valid bits and occupancy.
- cfg_we_i  in  1  request load of delay_sel_i.
- delay_sel_i  in  DW  requested delay, 0..MAX_DELAY.
- valid_i  in  1  input word valid.
- data_i  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- valid_o  out  1  valid bit at the active tap.
- data_o  out  CHANNELS*WIDTH  data at the active tap.
- delay_o  out  DW  active delay.
- occupancy_o  out  DW  valid words in stages 1..delay_o.
- idle_o  out  1  occupancy_o == 0.
- cfg_err_o  out  1  one-cycle pulse: cfg_we_i rejected.

## Operation
- Stages s = 1..MAX_DELAY each hold {valid, CHANNELS×WIDTH data}. Stage 0 is the input (valid_i, data_i).
- en_i=1: stage[s] <= stage[s-1] for all s, every cycle, regardless of valid. en_i=0: stages hold.
- Tap: if delay_o == 0, valid_o/data_o = valid_i/data_i (combinational bypass, independent of en_i). Otherwise valid_o/data_o = stage[delay_o].
- valid_o is not qualified by en_i; consumers qualify with en_i.
- Occupancy, evaluated when en_i=1 and delay_o>0: +1 if valid_i, −1 if valid_o, net 0 if both. It never exceeds delay_o and never underflows. When delay_o==0, occupancy stays 0.
- Config: cfg_we_i is accepted when idle_o=1 or flush_i=1. On acceptance, delay_o <= delay_sel_i, all stage valid bits are cleared, occupancy becomes 0, and data registers are untouched.
- If delay_sel_i > MAX_DELAY, the load is clamped to MAX_DELAY and cfg_err_o pulses.
- cfg_we_i while busy (idle_o=0, flush_i=0): delay_o is unchanged, cfg_err_o pulses for 1 cycle, and the pipeline is unaffected.
- flush_i: next cycle all valid bits are 0 and occupancy_o=0, regardless of en_i. A valid_i in the same cycle is dropped. Data registers are untouched.
- reset_i: all data and valid bits 0, occupancy 0, delay_o=DEFAULT_DELAY, cfg_err_o=0. reset_i overrides flush_i, cfg_we_i and en_i.

## Timing
- Reset values: valid_o=0, data_o=0, delay_o=DEFAULT_DELAY, occupancy_o=0, idle_o=1, cfg_err_o=0. If DEFAULT_DELAY=0, valid_o and data_o follow the inputs.
- Latency is D = delay_o enabled cycles: a word accepted on enabled edge k appears at the tap after enabled edge k+D-1, i.e. in the cycle following D enabled edges. Cycles with en_i=0 do not count.
- A new delay is effective from the cycle after acceptance. A word presented in the acceptance cycle is dropped, because its valid bit is cleared.
- cfg_err_o is registered and asserts the cycle after the rejected request.
- occupancy_o and idle_o are registered and reflect the state after the last edge.
- Throughput: one word per enabled cycle at any delay.

## Test plan
- Reset, DEFAULT_DELAY=2: send valid words 0x00001,0x00002,0x00003 on 3 consecutive en cycles → valid_o is high for 3 cycles starting after edge 2 with the same data in order; occupancy peaks at 2, then returns to 0 and idle_o=1.
- en_i gaps: with delay 3, one word 0x1ABCD, then en_i low for 4 cycles mid-flight → the word emerges only after 3 enabled edges, and occupancy holds at 1 during the gap.
- Reconfigure: when idle, cfg_we_i with delay_sel_i=0 → delay_o=0 and data_o tracks data_i combinationally. Then cfg_we_i with 8 → latency 8. cfg_we_i with 9 (MAX_DELAY=8) → delay_o=8 and cfg_err_o pulses.
- Busy rejection: with delay 4 and 2 words in flight, pulse cfg_we_i with 1 → cfg_err_o=1 for one cycle, delay_o stays 4, and both words exit intact.
- Flush: with delay 5 and 3 words in flight, assert flush_i together with valid_i → no valid_o for the next 6 cycles, occupancy_o=0, and a same-cycle cfg_we_i with 1 is accepted.
- Reset mid-operation: 4 words in flight at delay 6, assert reset_i while en_i=0 → all outputs return to reset values after the edge and no stale valid_o appears afterwards.
